// File: rtl/rfp_i2c_sequencer.sv
// Wishbone master that initialises the RF-path I2C master cores and turns
// register-level read/write commands into START/address/data/STOP byte steps,
// polling each core's status register and returning one response per command.
module rfp_i2c_sequencer #(
  parameter int unsigned NUM_BUS        = 5,
  parameter logic [15:0] PRESCALE       = 16'd99,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [15:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rd_i,
  input  logic [2:0]  cmd_bus_i,
  input  logic [6:0]  cmd_dev_i,
  input  logic [7:0]  cmd_reg_i,
  input  logic        cmd_len_i,
  input  logic [15:0] cmd_dat_i,
  output logic        rsp_valid_o,
  output logic [1:0]  rsp_err_o,
  output logic [15:0] rsp_dat_o,
  output logic        init_done_o
);

  // Core register indices
  localparam logic [2:0] RegPrerLo = 3'd0;
  localparam logic [2:0] RegPrerHi = 3'd1;
  localparam logic [2:0] RegCtr    = 3'd2;
  localparam logic [2:0] RegTxRx   = 3'd3;
  localparam logic [2:0] RegCrSr   = 3'd4;

  // Command register flag combinations
  localparam logic [7:0] CrStaWr   = 8'h90;
  localparam logic [7:0] CrWr      = 8'h10;
  localparam logic [7:0] CrWrSto   = 8'h50;
  localparam logic [7:0] CrRd      = 8'h20;
  localparam logic [7:0] CrRdNkSto = 8'h68;
  localparam logic [7:0] CrSto     = 8'h40;

  localparam logic [3:0] NumBusW  = 4'(NUM_BUS);
  localparam logic [2:0] LastBus  = 3'(NUM_BUS - 1);

  typedef enum logic [3:0] {
    StInit,
    StIdle,
    StTxr,
    StCr,
    StPoll,
    StRxr,
    StStopCr,
    StStopPoll,
    StAbortCr,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        gap_q, gap_d;
  logic [2:0]  init_bus_q, init_bus_d;
  logic [1:0]  init_step_q, init_step_d;
  logic        init_done_q, init_done_d;
  logic        rd_q, rd_d;
  logic [2:0]  bus_q, bus_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic        len_q, len_d;
  logic [15:0] dat_q, dat_d;
  logic [2:0]  step_q, step_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] rx_q, rx_d;
  logic [19:0] poll_cnt_q, poll_cnt_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [15:0] rsp_dat_q, rsp_dat_d;

  logic        acc_req, acc_we, cyc, wb_term, wb_fail;
  logic [2:0]  acc_bus, acc_reg;
  logic [7:0]  acc_byte;
  logic        read_step, last_step, sr_tip, sr_rxack, timed_out;
  logic [2:0]  last_idx, step_inc;
  logic [7:0]  tx_byte, cr_flags;
  logic        unused_dat;

  assign unused_dat = ^wbm_dat_i[31:8];

  // Byte-sequence decode for the current step of the active command
  always_comb begin
    read_step = rd_q && (step_q >= 3'd3);
    last_idx  = (rd_q ? 3'd3 : 3'd2) + {2'b00, len_q};
    last_step = (step_q == last_idx);
    step_inc  = step_q + 3'd1;
    sr_tip    = wbm_dat_i[1];
    sr_rxack  = wbm_dat_i[7];
    timed_out = (poll_cnt_q >= TIMEOUT_CYCLES);
    unique case (step_q)
      3'd0:    tx_byte = {dev_q, 1'b0};
      3'd1:    tx_byte = reg_q;
      3'd2:    tx_byte = rd_q ? {dev_q, 1'b1} : (len_q ? dat_q[15:8] : dat_q[7:0]);
      3'd3:    tx_byte = dat_q[7:0];
      default: tx_byte = 8'h00;
    endcase
    if (read_step) begin
      cr_flags = last_step ? CrRdNkSto : CrRd;
    end else if ((step_q == 3'd0) || (rd_q && (step_q == 3'd2))) begin
      cr_flags = CrStaWr;
    end else begin
      cr_flags = last_step ? CrWrSto : CrWr;
    end
  end

  // Wishbone access descriptor for the current state
  always_comb begin
    acc_req  = 1'b0;
    acc_we   = 1'b0;
    acc_bus  = bus_q;
    acc_reg  = RegCrSr;
    acc_byte = 8'h00;
    unique case (state_q)
      StInit: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_bus = init_bus_q;
        unique case (init_step_q)
          2'd0:    begin acc_reg = RegCtr;    acc_byte = 8'h00;          end
          2'd1:    begin acc_reg = RegPrerLo; acc_byte = PRESCALE[7:0];  end
          2'd2:    begin acc_reg = RegPrerHi; acc_byte = PRESCALE[15:8]; end
          default: begin acc_reg = RegCtr;    acc_byte = 8'h80;          end
        endcase
      end
      StTxr:      begin acc_req = 1'b1; acc_we = 1'b1; acc_reg = RegTxRx; acc_byte = tx_byte; end
      StCr:       begin acc_req = 1'b1; acc_we = 1'b1; acc_byte = cr_flags; end
      StPoll:     acc_req = 1'b1;
      StRxr:      begin acc_req = 1'b1; acc_reg = RegTxRx; end
      StStopCr,
      StAbortCr:  begin acc_req = 1'b1; acc_we = 1'b1; acc_byte = CrSto; end
      StStopPoll: acc_req = 1'b1;
      default:    acc_req = 1'b0;
    endcase
  end

  // Bus outputs; everything is zero outside an access, including the gap cycle
  always_comb begin
    cyc         = acc_req && !gap_q;
    wb_term     = cyc && (wbm_ack_i || wbm_err_i || wbm_rty_i);
    wb_fail     = wbm_err_i || wbm_rty_i;
    wbm_cyc_o   = cyc;
    wbm_stb_o   = cyc;
    wbm_we_o    = cyc && acc_we;
    wbm_sel_o   = cyc ? 4'hF : 4'h0;
    wbm_adr_o   = cyc ? {8'h00, acc_bus, acc_reg, 2'b00} : 16'h0000;
    wbm_dat_o   = (cyc && acc_we) ? {24'h000000, acc_byte} : 32'h0;
    cmd_ready_o = (state_q == StIdle);
    rsp_valid_o = (state_q == StResp);
    rsp_err_o   = rsp_err_q;
    rsp_dat_o   = rsp_dat_q;
    init_done_o = init_done_q;
  end

  // Next-state logic for the sequencer
  always_comb begin
    state_d     = state_q;
    gap_d       = wb_term;
    init_bus_d  = init_bus_q;
    init_step_d = init_step_q;
    init_done_d = init_done_q;
    rd_d        = rd_q;
    bus_d       = bus_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    len_d       = len_q;
    dat_d       = dat_q;
    step_d      = step_q;
    code_d      = code_q;
    rx_d        = rx_q;
    poll_cnt_d  = poll_cnt_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;

    if (((state_q == StPoll) || (state_q == StStopPoll)) && (poll_cnt_q != '1)) begin
      poll_cnt_d = poll_cnt_q + 20'd1;
    end

    unique case (state_q)
      StInit: begin
        // Bus errors during initialisation are deliberately ignored
        if (wb_term) begin
          if (init_step_q == 2'd3) begin
            init_step_d = 2'd0;
            if (init_bus_q == LastBus) begin
              init_done_d = 1'b1;
              state_d     = StIdle;
            end else begin
              init_bus_d = init_bus_q + 3'd1;
            end
          end else begin
            init_step_d = init_step_q + 2'd1;
          end
        end
      end
      StIdle: begin
        if (cmd_valid_i) begin
          rd_d   = cmd_rd_i;
          bus_d  = cmd_bus_i;
          dev_d  = cmd_dev_i;
          reg_d  = cmd_reg_i;
          len_d  = cmd_len_i;
          dat_d  = cmd_dat_i;
          step_d = 3'd0;
          code_d = 2'd0;
          rx_d   = 16'h0000;
          if ({1'b0, cmd_bus_i} >= NumBusW) begin
            code_d  = 2'd3;
            state_d = StResp;
          end else begin
            state_d = StTxr;
          end
        end
      end
      StTxr: begin
        if (wb_term) begin
          if (wb_fail) begin
            code_d  = 2'd3;
            state_d = StStopCr;
          end else begin
            state_d = StCr;
          end
        end
      end
      StCr: begin
        if (wb_term) begin
          if (wb_fail) begin
            code_d  = 2'd3;
            state_d = StStopCr;
          end else begin
            poll_cnt_d = 20'd0;
            state_d    = StPoll;
          end
        end
      end
      StPoll: begin
        if (wb_term) begin
          if (wb_fail) begin
            code_d  = 2'd3;
            state_d = StStopCr;
          end else if (sr_tip) begin
            if (timed_out) begin
              code_d  = 2'd2;
              state_d = StAbortCr;
            end
          end else if (read_step) begin
            state_d = StRxr;
          end else if (sr_rxack) begin
            code_d  = 2'd1;
            state_d = StStopCr;
          end else if (last_step) begin
            state_d = StResp;
          end else begin
            step_d  = step_inc;
            // Read data bytes need no TXR load, only a command write
            state_d = (rd_q && (step_inc >= 3'd3)) ? StCr : StTxr;
          end
        end
      end
      StRxr: begin
        if (wb_term) begin
          if (wb_fail) begin
            code_d  = 2'd3;
            state_d = StStopCr;
          end else begin
            // Shifting left puts the first byte of a 2-byte read in [15:8]
            rx_d = {rx_q[7:0], wbm_dat_i[7:0]};
            if (last_step) begin
              state_d = StResp;
            end else begin
              step_d  = step_inc;
              state_d = StCr;
            end
          end
        end
      end
      StStopCr: begin
        if (wb_term) begin
          if (wb_fail) begin
            code_d  = 2'd3;
            state_d = StResp;
          end else begin
            poll_cnt_d = 20'd0;
            state_d    = StStopPoll;
          end
        end
      end
      StStopPoll: begin
        if (wb_term) begin
          if (wb_fail) begin
            code_d  = 2'd3;
            state_d = StResp;
          end else if (!sr_tip) begin
            state_d = StResp;
          end else if (timed_out) begin
            code_d  = 2'd2;
            state_d = StResp;
          end
        end
      end
      StAbortCr: begin
        // Timeout already recorded; respond without waiting on the core
        if (wb_term) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Capture the response as the FSM enters StResp so it is valid with the pulse
    if ((state_d == StResp) && (state_q != StResp)) begin
      rsp_err_d = code_d;
      rsp_dat_d = rd_d ? rx_d : 16'h0000;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StInit;
      gap_q       <= 1'b1;
      init_bus_q  <= 3'd0;
      init_step_q <= 2'd0;
      init_done_q <= 1'b0;
      rd_q        <= 1'b0;
      bus_q       <= 3'd0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      len_q       <= 1'b0;
      dat_q       <= 16'd0;
      step_q      <= 3'd0;
      code_q      <= 2'd0;
      rx_q        <= 16'd0;
      poll_cnt_q  <= 20'd0;
      rsp_err_q   <= 2'd0;
      rsp_dat_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      init_bus_q  <= init_bus_d;
      init_step_q <= init_step_d;
      init_done_q <= init_done_d;
      rd_q        <= rd_d;
      bus_q       <= bus_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      len_q       <= len_d;
      dat_q       <= dat_d;
      step_q      <= step_d;
      code_q      <= code_d;
      rx_q        <= rx_d;
      poll_cnt_q  <= poll_cnt_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

endmodule
